ram_input_arbiter: RTL

Two-port arbiter and sequencer for the single-port input RAM (synchronous write, registered read address). It shares the RAM between requester A (image loader, mostly writes) and requester B (compute unit, mostly reads), granting at most one access per cycle round-robin and returning read data one cycle after grant with a valid strobe. It sits directly in front of the input RAM; nothing else drives the RAM ports. Optionally, after reset, it zero-fills the RAM before accepting requests.

---
 rtl/ram_input_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/ram_input_arbiter.sv
// Round-robin two-port arbiter in front of the single-port input RAM.
// Optional post-reset zero fill when RAM_CLEAR_ON_RESET_EN is defined.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   a_req/a_we/a_addr/a_wdata requester A (image loader)
//   b_req/b_we/b_addr/b_wdata requester B (compute unit)
//   a_gnt, b_gnt              combinational grants, access at this edge
//   a_rvalid, b_rvalid        read data valid on rdata, one cycle later
//   rdata                     read data (copy of ram_q)
//   ram_addr/ram_data/ram_we  RAM drive; ram_q RAM read data
//   busy                      high while the RAM is being cleared
module ram_input_arbiter #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy
);

  logic                  clearing;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  last_b;

`ifdef RAM_CLEAR_ON_RESET_EN
  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt)
        state <= RUN;
    end
  end

  assign clearing = (state == CLEAR);
  assign clr_addr = clr_cnt;
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  assign busy  = clearing;
  assign rdata = ram_q;

  // Ties go to whoever was not granted last; last_b resets to B
  // so A wins the first tie.
  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_data = '0;
    if (clearing) begin
      ram_we   = 1'b1;
      ram_addr = clr_addr;
    end else begin
      a_gnt = a_req & (~b_req | last_b);
      b_gnt = b_req & ~a_gnt;
      if (a_gnt) begin
        ram_we   = a_we;
        ram_addr = a_addr;
        ram_data = a_wdata;
      end else if (b_gnt) begin
        ram_we   = b_we;
        ram_addr = b_addr;
        ram_data = b_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b   <= 1'b1;
      addr_q   <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      addr_q   <= ram_addr;
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt)
        last_b <= 1'b0;
      else if (b_gnt)
        last_b <= 1'b1;
    end
  end

endmodule
